// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU: operation codes, aluOp encodings,
// iterative-unit FSM states and the M-extension funct7 marker.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
        OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
        OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } alu_op_e;

    localparam logic [1:0] ALUOP_ADD     = 2'b00;
    localparam logic [1:0] ALUOP_SUB     = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT   = 2'b10;
    localparam logic [1:0] ALUOP_ADD_ALT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE, ST_MUL, ST_DIV, ST_DONE
    } alu_state_e;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    function automatic logic is_mul_op(input alu_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
    endfunction

    function automatic logic is_div_op(input alu_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_exec_unit_op_decode.sv
// Combinational decode of aluOp/opcode/funct fields into a single ALU op code.
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int MULDIV_EN = 1
) (
    input  logic [1:0] i_aluOp,
    input  logic       i_op5,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    output alu_op_e    o_op
);

    always_comb begin
        o_op = OP_ADD;
        case (i_aluOp)
            ALUOP_ADD, ALUOP_ADD_ALT: o_op = OP_ADD;
            ALUOP_SUB:                o_op = OP_SUB;
            ALUOP_FUNCT: begin
                // The M encoding only exists when the iterative core is built.
                if ((MULDIV_EN != 0) && i_op5 && (i_funct7 == FUNCT7_MULDIV)) begin
                    case (i_funct3)
                        3'b000: o_op = OP_MUL;
                        3'b001: o_op = OP_MULH;
                        3'b010: o_op = OP_MULHSU;
                        3'b011: o_op = OP_MULHU;
                        3'b100: o_op = OP_DIV;
                        3'b101: o_op = OP_DIVU;
                        3'b110: o_op = OP_REM;
                        3'b111: o_op = OP_REMU;
                    endcase
                end else begin
                    case (i_funct3)
                        3'b000: o_op = (i_op5 && i_funct7[5]) ? OP_SUB : OP_ADD;
                        3'b001: o_op = OP_SLL;
                        3'b010: o_op = OP_SLT;
                        3'b011: o_op = OP_SLTU;
                        3'b100: o_op = OP_XOR;
                        3'b101: o_op = i_funct7[5] ? OP_SRA : OP_SRL;
                        3'b110: o_op = OP_OR;
                        3'b111: o_op = OP_AND;
                    endcase
                end
            end
            default: o_op = OP_ADD;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle integer ops plus an optional iterative
// shift-add multiplier / restoring divider sharing one set of work registers.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MULDIV_EN = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [1:0]      aluOp_i,
    input  logic            op5_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic [XLEN-1:0] srcA_i,
    input  logic [XLEN-1:0] srcB_i,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o
);

    localparam int SHW  = $clog2(XLEN);
    localparam int CNTW = SHW + 1;

    alu_op_e         w_op;
    alu_state_e      r_state;
    alu_state_e      w_stateNext;
    logic            w_accept;
    logic            w_isMul;
    logic            w_isDiv;
    logic            w_special;
    logic            w_done;
    logic            w_lastIter;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_baseResult;
    logic [XLEN-1:0] w_specResult;
    logic [XLEN-1:0] w_immResult;
    logic [XLEN-1:0] w_mdResult;
    logic [XLEN-1:0] r_result;
    logic            r_valid;
    logic            r_zero;
    logic            w_divZero;
    logic            w_divOvf;

    alu_op_decode #(.MULDIV_EN(MULDIV_EN)) u_decode (
        .i_aluOp  (aluOp_i),
        .i_op5    (op5_i),
        .i_funct3 (funct3_i),
        .i_funct7 (funct7_i),
        .o_op     (w_op)
    );

    assign ready_o  = (r_state == ST_IDLE) & ~rst_i;
    assign w_accept = valid_i & ready_o;
    assign w_isMul  = is_mul_op(w_op);
    assign w_isDiv  = is_div_op(w_op);
    assign w_done   = (r_state == ST_DONE);
    assign w_shamt  = srcB_i[SHW-1:0];

    always_comb begin
        w_baseResult = '0;
        case (w_op)
            OP_ADD:  w_baseResult = srcA_i + srcB_i;
            OP_SUB:  w_baseResult = srcA_i - srcB_i;
            OP_SLL:  w_baseResult = srcA_i << w_shamt;
            OP_SLT:  w_baseResult = {{(XLEN-1){1'b0}}, ($signed(srcA_i) < $signed(srcB_i))};
            OP_SLTU: w_baseResult = {{(XLEN-1){1'b0}}, (srcA_i < srcB_i)};
            OP_XOR:  w_baseResult = srcA_i ^ srcB_i;
            OP_SRL:  w_baseResult = srcA_i >> w_shamt;
            OP_SRA:  w_baseResult = $unsigned($signed(srcA_i) >>> w_shamt);
            OP_OR:   w_baseResult = srcA_i | srcB_i;
            OP_AND:  w_baseResult = srcA_i & srcB_i;
            default: w_baseResult = '0;
        endcase
    end

    assign w_divZero = (srcB_i == '0);
    assign w_divOvf  = (srcA_i == {1'b1, {(XLEN-1){1'b0}}}) && (srcB_i == '1);

    // Divide-by-zero and signed overflow have fixed answers, so they finish
    // at base-op latency instead of running the divider.
    always_comb begin
        w_special    = 1'b0;
        w_specResult = '0;
        case (w_op)
            OP_DIV: begin
                if (w_divZero) begin
                    w_special    = 1'b1;
                    w_specResult = '1;
                end else if (w_divOvf) begin
                    w_special    = 1'b1;
                    w_specResult = srcA_i;
                end
            end
            OP_DIVU: begin
                w_special    = w_divZero;
                w_specResult = '1;
            end
            OP_REM: begin
                if (w_divZero) begin
                    w_special    = 1'b1;
                    w_specResult = srcA_i;
                end else if (w_divOvf) begin
                    w_special    = 1'b1;
                    w_specResult = '0;
                end
            end
            OP_REMU: begin
                w_special    = w_divZero;
                w_specResult = srcA_i;
            end
            default: ;
        endcase
    end

    assign w_immResult = w_isDiv ? w_specResult : w_baseResult;

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_isMul)
                    w_stateNext = ST_MUL;
                else if (w_accept && w_isDiv && !w_special)
                    w_stateNext = ST_DIV;
            end
            ST_MUL, ST_DIV: begin
                if (w_lastIter)
                    w_stateNext = ST_DONE;
            end
            ST_DONE: w_stateNext = ST_IDLE;
            default: w_stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_state <= ST_IDLE;
        else
            r_state <= w_stateNext;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_accept && !w_isMul && !(w_isDiv && !w_special)) begin
                r_valid  <= 1'b1;
                r_result <= w_immResult;
                r_zero   <= (w_immResult == '0);
            end else if (w_done) begin
                r_result <= w_mdResult;
                r_zero   <= (w_mdResult == '0);
            end
        end
    end

    // The DONE cycle presents the corrected iterative result directly so the
    // pulse lands XLEN+1 cycles after accept; it is held in r_result afterwards.
    assign valid_o  = ~rst_i & (r_valid | w_done);
    assign result_o = rst_i ? '0 : (w_done ? w_mdResult : r_result);
    assign zero_o   = ~rst_i & (w_done ? (w_mdResult == '0) : r_zero);

    generate
        if (MULDIV_EN != 0) begin : g_muldiv
            logic [XLEN-1:0]   r_hi;
            logic [XLEN-1:0]   r_lo;
            logic [XLEN-1:0]   r_opnd;
            logic [CNTW-1:0]   r_count;
            logic              r_negRes;
            logic              r_negA;
            alu_op_e           r_op;
            logic              w_aSigned;
            logic              w_bSigned;
            logic              w_negA;
            logic              w_negB;
            logic [XLEN-1:0]   w_magA;
            logic [XLEN-1:0]   w_magB;
            logic [XLEN:0]     w_sum;
            logic [XLEN:0]     w_trial;
            logic [2*XLEN-1:0] w_prod;
            logic [2*XLEN-1:0] w_prodOut;
            logic [XLEN-1:0]   w_quot;
            logic [XLEN-1:0]   w_rem;

            assign w_aSigned = (w_op == OP_MULH) || (w_op == OP_MULHSU) ||
                               (w_op == OP_DIV)  || (w_op == OP_REM);
            assign w_bSigned = (w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM);
            assign w_negA    = w_aSigned & srcA_i[XLEN-1];
            assign w_negB    = w_bSigned & srcB_i[XLEN-1];
            assign w_magA    = w_negA ? -srcA_i : srcA_i;
            assign w_magB    = w_negB ? -srcB_i : srcB_i;

            // r_hi is the product high half / partial remainder, r_lo the
            // multiplier / dividend shifting out, r_opnd multiplicand / divisor.
            assign w_sum     = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opnd : '0)};
            assign w_trial   = {r_hi, r_lo[XLEN-1]} - {1'b0, r_opnd};
            assign w_lastIter = (r_count == CNTW'(XLEN-1));

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_hi     <= '0;
                    r_lo     <= '0;
                    r_opnd   <= '0;
                    r_count  <= '0;
                    r_negRes <= 1'b0;
                    r_negA   <= 1'b0;
                    r_op     <= OP_ADD;
                end else if (w_accept) begin
                    r_op     <= w_op;
                    r_count  <= '0;
                    r_negRes <= w_negA ^ w_negB;
                    r_negA   <= w_negA;
                    r_hi     <= '0;
                    r_lo     <= w_isMul ? w_magB : w_magA;
                    r_opnd   <= w_isMul ? w_magA : w_magB;
                end else if (r_state == ST_MUL) begin
                    r_hi    <= w_sum[XLEN:1];
                    r_lo    <= {w_sum[0], r_lo[XLEN-1:1]};
                    r_count <= r_count + CNTW'(1);
                end else if (r_state == ST_DIV) begin
                    if (!w_trial[XLEN]) begin
                        r_hi <= w_trial[XLEN-1:0];
                        r_lo <= {r_lo[XLEN-2:0], 1'b1};
                    end else begin
                        r_hi <= {r_hi[XLEN-2:0], r_lo[XLEN-1]};
                        r_lo <= {r_lo[XLEN-2:0], 1'b0};
                    end
                    r_count <= r_count + CNTW'(1);
                end
            end

            assign w_prod    = {r_hi, r_lo};
            assign w_prodOut = r_negRes ? -w_prod : w_prod;
            assign w_quot    = r_negRes ? -r_lo : r_lo;
            assign w_rem     = r_negA ? -r_hi : r_hi;

            always_comb begin
                w_mdResult = w_rem;
                case (r_op)
                    OP_MUL:                       w_mdResult = w_prodOut[XLEN-1:0];
                    OP_MULH, OP_MULHSU, OP_MULHU: w_mdResult = w_prodOut[2*XLEN-1:XLEN];
                    OP_DIV, OP_DIVU:              w_mdResult = w_quot;
                    default:                      w_mdResult = w_rem;
                endcase
            end
        end else begin : g_noMuldiv
            assign w_mdResult = '0;
            assign w_lastIter = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit, with a second instance
// built without the M extension to check its fallback decode.
module tb_alu_exec_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        validIn = 1'b0;
   logic [1:0]  aluOp = 2'b00;
   logic        op5 = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [6:0]  funct7 = 7'b0000000;
   logic [31:0] srcA = 32'h0;
   logic [31:0] srcB = 32'h0;

   logic        ready, validOut, zero;
   logic [31:0] result;
   logic        readyNm, validNm, zeroNm;
   logic [31:0] resultNm;

   int assertCount = 0;
   int failCount = 0;

   // Free-running 10 ns clock
   always #5 clock = ~clock;

   alu_exec_unit #(.XLEN(32), .MULDIV_EN(1)) dut (
      .clk_i    (clock),
      .rst_i    (reset),
      .valid_i  (validIn),
      .ready_o  (ready),
      .aluOp_i  (aluOp),
      .op5_i    (op5),
      .funct3_i (funct3),
      .funct7_i (funct7),
      .srcA_i   (srcA),
      .srcB_i   (srcB),
      .valid_o  (validOut),
      .result_o (result),
      .zero_o   (zero)
   );

   alu_exec_unit #(.XLEN(32), .MULDIV_EN(0)) dutNoMd (
      .clk_i    (clock),
      .rst_i    (reset),
      .valid_i  (validIn),
      .ready_o  (readyNm),
      .aluOp_i  (aluOp),
      .op5_i    (op5),
      .funct3_i (funct3),
      .funct7_i (funct7),
      .srcA_i   (srcA),
      .srcB_i   (srcB),
      .valid_o  (validNm),
      .result_o (resultNm),
      .zero_o   (zeroNm)
   );

   // Advance to just after the next rising edge, where outputs are stable
   task automatic nextCycle;
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] op, input logic o5, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
      aluOp   = op;
      op5     = o5;
      funct3  = f3;
      funct7  = f7;
      srcA    = a;
      srcB    = b;
      validIn = 1'b1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Single-cycle op: result must appear on the very next cycle
   task automatic runBase(input string tag, input logic [1:0] op, input logic o5, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expResult, input logic expZero);
      applyStimulus(op, o5, f3, f7, a, b);
      nextCycle();
      checkOutput({tag, " valid"}, {31'b0, validOut}, 32'd1);
      checkOutput({tag, " result"}, result, expResult);
      checkOutput({tag, " zero"}, {31'b0, zero}, {31'b0, expZero});
   endtask

   // M-extension op: measure latency and ready-low cycles while pulsing valid_i
   task automatic runOp(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expResult, input int expLat);
      int lat;
      int lowCycles;
      lat = 0;
      lowCycles = 0;
      applyStimulus(2'b10, 1'b1, f3, 7'b0000001, a, b);
      while (lat < 40) begin
         nextCycle();
         lat++;
         if (!ready) lowCycles++;
         if (validOut) break;
         validIn = lat[0];
      end
      validIn = 1'b0;
      checkOutput({tag, " latency"}, lat, expLat);
      checkOutput({tag, " result"}, result, expResult);
      checkOutput({tag, " readyLow"}, lowCycles, (expLat > 1) ? expLat : 0);
      nextCycle();
      checkOutput({tag, " readyAfter"}, {31'b0, ready}, 32'd1);
      checkOutput({tag, " noExtraValid"}, {31'b0, validOut}, 32'd0);
      checkOutput({tag, " held"}, result, expResult);
   endtask

   // Bound the whole run so a hung DUT still terminates
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main directed sequence
   initial begin
      int pulses;
      int lat;

      nextCycle();
      checkOutput("reset valid", {31'b0, validOut}, 32'd0);
      checkOutput("reset result", result, 32'h0);
      checkOutput("reset ready", {31'b0, ready}, 32'd0);
      checkOutput("reset zero", {31'b0, zero}, 32'd0);
      nextCycle();
      reset = 1'b0;
      #1;
      checkOutput("ready after reset", {31'b0, ready}, 32'd1);

      runBase("sub", 2'b10, 1'b1, 3'b000, 7'b0100000, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0);
      runBase("sra", 2'b10, 1'b1, 3'b101, 7'b0100000, 32'h80000000, 32'd36, 32'hF8000000, 1'b0);
      runBase("slt", 2'b10, 1'b1, 3'b010, 7'b0000000, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0);
      runBase("sltu", 2'b10, 1'b1, 3'b011, 7'b0000000, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1);
      runBase("sll", 2'b10, 1'b1, 3'b001, 7'b0000000, 32'd1, 32'd33, 32'd2, 1'b0);
      runBase("srl", 2'b10, 1'b1, 3'b101, 7'b0000000, 32'h80000000, 32'd4, 32'h08000000, 1'b0);
      runBase("and", 2'b10, 1'b1, 3'b111, 7'b0000000, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0);
      runBase("aluop sub", 2'b01, 1'b0, 3'b000, 7'b0000000, 32'd10, 32'd3, 32'd7, 1'b0);
      runBase("itype add", 2'b10, 1'b0, 3'b000, 7'b0100000, 32'd5, 32'd7, 32'd12, 1'b0);
      validIn = 1'b0;
      nextCycle();
      checkOutput("idle valid", {31'b0, validOut}, 32'd0);
      checkOutput("idle hold", result, 32'd12);

      runOp("mulh", 3'b001, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 33);
      runOp("mul", 3'b000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 33);
      runOp("mulhsu", 3'b010, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 33);
      runOp("mulhu", 3'b011, 32'hFFFFFFFD, 32'd7, 32'h00000006, 33);
      runOp("div", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
      runOp("rem", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
      runOp("remu", 3'b111, 32'd100, 32'd7, 32'd2, 33);
      runOp("divu by zero", 3'b101, 32'd9, 32'd0, 32'hFFFFFFFF, 1);
      runOp("div overflow", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      runOp("rem overflow", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
      runOp("rem by zero", 3'b110, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 1);

      // Reset ten cycles into a divide must kill it silently
      applyStimulus(2'b10, 1'b1, 3'b100, 7'b0000001, 32'hFFFFFFF9, 32'd2);
      nextCycle();
      validIn = 1'b0;
      repeat (9) nextCycle();
      reset = 1'b1;
      #1;
      checkOutput("abort ready", {31'b0, ready}, 32'd0);
      checkOutput("abort valid", {31'b0, validOut}, 32'd0);
      checkOutput("abort result", result, 32'h0);
      nextCycle();
      reset = 1'b0;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         nextCycle();
         if (validOut) pulses++;
      end
      checkOutput("abort no valid", pulses, 0);
      runBase("add after abort", 2'b00, 1'b0, 3'b000, 7'b0000000, 32'd3, 32'd4, 32'd7, 1'b0);
      validIn = 1'b0;
      nextCycle();

      // M encoding falls back to ADD without the iterative core
      applyStimulus(2'b10, 1'b1, 3'b000, 7'b0000001, 32'd3, 32'd4);
      nextCycle();
      validIn = 1'b0;
      checkOutput("nomd valid", {31'b0, validNm}, 32'd1);
      checkOutput("nomd result", resultNm, 32'd7);
      checkOutput("md busy", {31'b0, validOut}, 32'd0);
      lat = 1;
      while (!validOut && lat < 40) begin
         nextCycle();
         lat++;
      end
      checkOutput("md mul latency", lat, 33);
      checkOutput("md mul result", result, 32'd12);
      nextCycle();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised execute-stage ALU that merges operation decode and datapath, and adds an iterative RV32M multiply/divide path. Sits between the main decoder (aluOp/funct fields) and the writeback mux in the single-core pipeline. Single-cycle integer ops return in one cycle. Multiply/divide ops hold the unit busy through a valid/ready handshake, and the core stalls on `ready_o`.

## Interface
- `XLEN`, 32: operand/result width; power of two, ≥ 8
- `MULDIV_EN`, 1: 1 enables M-extension decode and iterative core; 0 removes it
- `clk_i` input 1: clock
- `rst_i` input 1: reset; one clock, synchronous, active-high
- `valid_i` input 1: operation request
- `ready_o` output 1: unit can accept; op accepted when `valid_i & ready_o`
- `aluOp_i` input 2: 00 add, 01 sub, 10 decode funct fields, 11 treated as add
- `op5_i` input 1: opcode bit 5 (1 = R-type)
- `funct3_i` input 3: instruction funct3
- `funct7_i` input 7: full instruction funct7
- `srcA_i` input XLEN: operand A
- `srcB_i` input XLEN: operand B
- `valid_o` output 1: one-cycle pulse, result valid
- `result_o` output XLEN: result, held until next `valid_o`
- `zero_o` output 1: `result_o == 0`, registered with result

## Operation
- **Decode, aluOp=10, base ops by funct3:**
  - 000: ADD, or SUB when `op5_i & funct7_i[5]`
  - 001: SLL
  - 010: SLT
  - 011: SLTU
  - 100: XOR
  - 101: SRL, or SRA when `funct7_i[5]`
  - 110: OR
  - 111: AND
- **Decode, M ops:** when `MULDIV_EN & op5_i & funct7_i == 0000001`, funct3 selects:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- With `MULDIV_EN=0` that encoding falls to base decode.
- Shift amount = `srcB_i[$clog2(XLEN)-1:0]`. SLT/SLTU give 0 or 1, zero-extended.
- **FSM states:** IDLE, MUL, DIV, DONE.
  - IDLE: base op accepted → result registered, stays IDLE. MUL* → MUL. Div/rem → DIV, except special cases below.
  - MUL: shift-add over operand magnitudes; one bit per cycle for XLEN cycles → DONE.
  - DIV: restoring division over magnitudes; one bit per cycle for XLEN cycles → DONE.
  - DONE: applies sign correction, selects high/low product or quotient/remainder, registers the result, pulses `valid_o` → IDLE.
- **Signedness:** MULH treats both operands signed; MULHSU treats A signed, B unsigned; MULHU, DIVU and REMU are unsigned. Remainder sign follows dividend.
- **Special cases,** resolved in IDLE at base-op latency, FSM not entered:
  - divide by zero: quotient all-ones, remainder = A
  - signed overflow (A = −2^(XLEN−1), B = −1): quotient = A, remainder = 0
- Iteration counter: `$clog2(XLEN)+1` bits, cleared on accept, no wrap.
- `ready_o = (state == IDLE) & ~rst_i`. `valid_i` outside IDLE is ignored; operands and decoded op are latched on accept.
- **Reset:** any cycle with `rst_i` high gives `state=IDLE`, `valid_o=0`, `result_o=0`, `zero_o=0`, `ready_o=0`. Reset mid-MUL/DIV aborts without `valid_o`.

## Timing
- Base ops and special-case divides: accept at cycle T → `valid_o`/`result_o` at T+1. Back-to-back accepts every cycle are allowed.
- MUL/DIV: accept at T, busy T+1…T+XLEN, DONE at T+XLEN+1 with `valid_o`. Latency is XLEN+1 (33 at XLEN=32).
- `ready_o` is low T+1…T+XLEN+1 and high again at T+XLEN+2.
- There is no downstream backpressure; `valid_o` is never stalled.
- `ready_o` is combinational from state only, never from `valid_i`.

## Structure
- Shared package `alu_pkg` holds:
  - a 5-bit op enum: 10 base ops + 8 M ops
  - aluOp encodings
  - FSM state enum
  - the funct7 M-extension constant
- One sub-module `alu_op_decode`: purely combinational, maps aluOp/op5/funct3/funct7 to the op enum, gated by `MULDIV_EN`.
- Multiply/divide registers and counter live in the top module under `generate` on `MULDIV_EN`.

## Test plan
- **Reset:** hold `rst_i` 2 cycles → `valid_o=0`, `result_o=0`, `ready_o=0`. First cycle after release → `ready_o=1`.
- **Base ops, back-to-back:**
  - aluOp=10, op5=1, funct7=0100000, funct3=000, A=5, B=7 → next cycle `result_o=0xFFFFFFFE`, `zero_o=0`.
  - Following cycle, SRA A=0x80000000, B=36 → `result_o=0xF8000000`.
- **Multiply:**
  - MULH A=0xFFFFFFFD, B=7 → `valid_o` exactly 33 cycles later, `result_o=0xFFFFFFFF`.
  - MUL with the same operands → `0xFFFFFFEB`.
  - `ready_o` low for 33 cycles. Extra `valid_i` pulses while busy produce no extra `valid_o`.
- **Divide:**
  - DIV A=−7, B=2 → `0xFFFFFFFD` at latency 33.
  - REM A=−7, B=2 → `0xFFFFFFFF` at latency 33.
  - DIVU A=9, B=0 → `0xFFFFFFFF` at latency 1.
  - DIV 0x80000000 / 0xFFFFFFFF → `0x80000000` at latency 1.
- **Abort:** assert `rst_i` 10 cycles into a DIV → no `valid_o` ever for it. A new ADD 3+4 after release → `result_o=7` at latency 1.
- **MULDIV_EN=0:** op5=1, funct7=0000001, funct3=000, A=3, B=4 → ADD, `result_o=7`, latency 1.
